// File: rtl/mac_rx.sv
// Receive framer: finds preamble/SFD in the PHY nibble stream, assembles bytes,
// checks the FCS and presents the payload with last/error flags.
module mac_rx #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phy_rxd,
    input  logic       phy_rxctl,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_err,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int unsigned CW          = $clog2(MAX_LEN + 2);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    state_t          r_state, w_state_nxt;
    logic            r_odd;
    logic [3:0]      r_lo;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_crc;
    logic [7:0]      r_dl [0:4];
    logic [2:0]      r_dl_cnt;
    logic            r_emitted;

    logic            w_byte_done, w_over, w_full, w_bad, w_sfd;
    logic [7:0]      w_byte;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_valid, w_last, w_err, w_ok, w_ferr;

    assign w_byte_done = (r_state == DATA) && phy_rxctl && r_odd;
    assign w_byte      = {phy_rxd, r_lo};
    assign w_cnt_nxt   = r_cnt + CW'(1);
    assign w_over      = (w_cnt_nxt == CW'(MAX_LEN + 1));
    assign w_full      = (r_dl_cnt == 3'd5);
    assign w_bad       = r_odd || (r_cnt < CW'(MIN_LEN)) || (r_crc != CRC_RESIDUE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= DROP;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;
        w_ok        = 1'b0;
        w_ferr      = 1'b0;
        w_sfd       = 1'b0;
        case (r_state)
            DROP: if (!phy_rxctl) w_state_nxt = IDLE;
            IDLE: if (phy_rxctl) w_state_nxt = (phy_rxd == 4'h5) ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!phy_rxctl)
                    w_state_nxt = IDLE;
                else if (phy_rxd == 4'hD) begin
                    w_state_nxt = DATA;
                    w_sfd       = 1'b1;
                end else if (phy_rxd != 4'h5)
                    w_state_nxt = DROP;
            end
            DATA: begin
                if (!phy_rxctl) begin
                    w_state_nxt = IDLE;
                    if (w_full) begin
                        w_valid = 1'b1;
                        w_last  = 1'b1;
                        w_err   = w_bad;
                        w_ok    = !w_bad;
                        w_ferr  = w_bad;
                    end else
                        w_ferr = 1'b1;
                end else if (w_byte_done) begin
                    // Overlength replaces the normal emission of the oldest byte.
                    if (w_over) begin
                        w_state_nxt = DROP;
                        w_ferr      = 1'b1;
                        if (r_emitted) begin
                            w_valid = 1'b1;
                            w_last  = 1'b1;
                            w_err   = 1'b1;
                        end
                    end else if (w_full)
                        w_valid = 1'b1;
                end
            end
            default: w_state_nxt = DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_err     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            r_odd     <= 1'b0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_dl_cnt  <= '0;
            r_emitted <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) r_dl[i] <= '0;
        end else begin
            m_valid   <= w_valid;
            m_last    <= w_last;
            m_err     <= w_err;
            frame_ok  <= w_ok;
            frame_err <= w_ferr;
            if (w_valid) begin
                m_data    <= r_dl[4];
                r_emitted <= 1'b1;
            end
            if (w_sfd) begin
                r_odd     <= 1'b0;
                r_cnt     <= '0;
                r_crc     <= '1;
                r_dl_cnt  <= '0;
                r_emitted <= 1'b0;
            end else if (r_state == DATA && phy_rxctl) begin
                if (!r_odd) begin
                    r_lo  <= phy_rxd;
                    r_odd <= 1'b1;
                end else begin
                    r_odd   <= 1'b0;
                    r_crc   <= crc_byte(r_crc, w_byte);
                    r_cnt   <= w_cnt_nxt;
                    r_dl[0] <= w_byte;
                    for (int unsigned i = 1; i < 5; i++) r_dl[i] <= r_dl[i-1];
                    if (!w_full) r_dl_cnt <= r_dl_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: a frame-level model predicts payload bytes and
// end-of-frame pulses; one negedge process checks every DUT output against it.
module tb_mac_rx;

    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1518;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] phy_rxd = '0;
    logic       phy_rxctl = 1'b0;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_err, frame_ok, frame_err;

    always #5 clk = ~clk;

    mac_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .phy_rxd(phy_rxd), .phy_rxctl(phy_rxctl),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } exp_t;

    exp_t         exp_q[$];
    bit           exp_p[$];
    byte unsigned fb[$];
    int n_vec = 0, n_mis = 0;
    int seen_bytes = 0, seen_ok = 0, seen_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Standard Ethernet CRC-32 (final inversion) over the first len bytes.
    function automatic logic [31:0] crc32_n(input byte unsigned q[$], input int len);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < len; i++) begin
            c ^= {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void mk_payload(input int len);
        fb = {};
        for (int i = 0; i < len; i++) fb.push_back(byte'(i & 8'hFF));
    endfunction

    function automatic void add_fcs();
        logic [31:0] c;
        c = crc32_n(fb, fb.size());
        for (int i = 0; i < 4; i++) fb.push_back(byte'(c >> (8 * i)));
    endfunction

    // Frame-level prediction: which bytes appear, which is last, and the verdict.
    function automatic void model_frame(input byte unsigned q[$], input bit odd);
        int n;
        bit bad, fcs_ok;
        n = q.size();
        if (n >= int'(MAX_LEN) + 1) begin
            for (int k = 0; k <= int'(MAX_LEN) - 5; k++)
                exp_q.push_back('{d: q[k], last: k == int'(MAX_LEN) - 5, err: k == int'(MAX_LEN) - 5});
            exp_p.push_back(1'b0);
        end else begin
            fcs_ok = (n >= 4) && (crc32_n(q, n - 4) == {q[n-1], q[n-2], q[n-3], q[n-4]});
            bad = odd || (n < int'(MIN_LEN)) || !fcs_ok;
            if (n >= 5) begin
                for (int k = 0; k <= n - 5; k++)
                    exp_q.push_back('{d: q[k], last: k == n - 5, err: (k == n - 5) && bad});
                exp_p.push_back(!bad);
            end else
                exp_p.push_back(1'b0);
        end
    endfunction

    task automatic drive(input logic [3:0] n);
        phy_rxd   = n;
        phy_rxctl = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        phy_rxd   = '0;
        phy_rxctl = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 15; i++) drive(4'h5);
        drive(4'hD);
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            drive(fb[i][3:0]);
            drive(fb[i][7:4]);
        end
    endtask

    task automatic send_frame(input bit odd, input int gap);
        model_frame(fb, odd);
        send_preamble();
        send_bytes(0, fb.size());
        if (odd) drive(4'h0);
        idle(gap);
    endtask

    task automatic end_test(input string name, input int nb, input int nok, input int nerr);
        check({name, "_drained"}, exp_q.size() + exp_p.size(), 0);
        check({name, "_bytes"}, seen_bytes, nb);
        check({name, "_ok"}, seen_ok, nok);
        check({name, "_err"}, seen_err, nerr);
        seen_bytes = 0;
        seen_ok    = 0;
        seen_err   = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   p;
        if (m_valid) begin
            seen_bytes++;
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e.d);
                check("m_last", m_last, e.last);
                check("m_err", m_err, e.err);
            end
        end else
            check("flags_idle", {m_last, m_err}, 0);
        if (frame_ok || frame_err) begin
            check("pulse_expected", exp_p.size() != 0, 1);
            if (exp_p.size() != 0) begin
                p = exp_p.pop_front();
                check("frame_ok", frame_ok, p);
                check("frame_err", frame_err, !p);
            end
        end
        if (m_last) check("last_has_pulse", frame_ok | frame_err, 1);
        if (frame_ok) seen_ok++;
        if (frame_err) seen_err++;
    end

    initial begin
        byte unsigned kat[$];
        kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_crc_kat", crc32_n(kat, 9), 32'hCBF43926);

        rst = 1'b1;
        idle(3);
        check("reset_state", {m_data, m_valid, m_last, m_err, frame_ok, frame_err}, 0);
        rst = 1'b0;
        idle(3);

        mk_payload(60); add_fcs();
        send_frame(1'b0, 10);
        end_test("good", 60, 1, 0);

        mk_payload(60); add_fcs(); fb[10] ^= 8'h01;
        send_frame(1'b0, 10);
        end_test("bitflip", 60, 0, 1);

        mk_payload(16); add_fcs();
        send_frame(1'b0, 10);
        end_test("runt", 16, 0, 1);

        mk_payload(59); add_fcs();
        send_frame(1'b0, 10);
        end_test("min_minus1", 59, 0, 1);

        mk_payload(60); add_fcs();
        send_frame(1'b1, 10);
        end_test("odd_nibble", 60, 0, 1);

        // Preamble error: rest of the burst, SFD-looking nibbles included, is ignored.
        drive(4'h5); drive(4'h5); drive(4'h3);
        send_preamble();
        mk_payload(20);
        send_bytes(0, 20);
        idle(3);
        mk_payload(60); add_fcs();
        send_frame(1'b0, 10);
        end_test("preamble_err", 60, 1, 0);

        mk_payload(MAX_LEN - 4); add_fcs();
        send_frame(1'b0, 10);
        end_test("max_len", MAX_LEN - 4, 1, 0);

        mk_payload(1600);
        send_frame(1'b0, 10);
        end_test("overlength", MAX_LEN - 4, 0, 1);

        // Reset mid-frame after five payload bytes have been emitted.
        mk_payload(60); add_fcs();
        for (int k = 0; k < 5; k++) exp_q.push_back('{d: fb[k], last: 1'b0, err: 1'b0});
        send_preamble();
        send_bytes(0, 10);
        rst = 1'b1;
        drive(fb[10][3:0]);
        check("mid_reset_outputs", {m_data, m_valid, m_last, m_err, frame_ok, frame_err}, 0);
        rst = 1'b0;
        drive(fb[10][7:4]);
        send_bytes(11, fb.size());
        idle(10);
        end_test("mid_reset", 5, 0, 0);
        send_frame(1'b0, 10);
        end_test("after_reset", 60, 1, 0);

        // Back-to-back frames separated by a single idle cycle.
        mk_payload(60); add_fcs();
        send_frame(1'b0, 1);
        mk_payload(61); add_fcs();
        send_frame(1'b0, 10);
        end_test("back_to_back", 121, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
